// File: rtl/vram_pkg.sv
// Shared types and frame-buffer geometry for the VRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_pkg;

    localparam int FB_W        = 320;
    localparam int FB_H        = 240;
    localparam int FB_WORDS    = FB_W * FB_H;
    localparam int VRAM_ADDR_W = 17;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_WR,
        GNT_CPU
    } gnt_t;

    // Which shared-slot requester wins the next tie.
    typedef enum logic {
        RR_WR,
        RR_CPU
    } rr_t;

    // CPU access: idle, waiting for a slot, waiting for the BRAM read cycle.
    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_PEND,
        CPU_WAIT
    } cpu_st_t;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/vram_wfifo.sv
// Generic synchronous FIFO holding buffered draw writes.
// Latency: an entry pushed in cycle t is visible at the head in cycle t+1.
// Backpressure: full comes from the registered count, so a same-cycle pop never reopens it.
module vram_wfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [WIDTH-1:0] buf_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = buf_q[rd_ptr_q];

    // Next storage, pointers and occupancy from push/pop.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            buf_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port frame-buffer BRAM between display reads, draw writes and CPU accesses.
// Latency: display read data 2 cycles after request; CPU ack 2 cycles after its grant.
// Backpressure: draw writes stall on wr_ready (FIFO full); CPU holds cpu_busy until cpu_ack.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int DATA_W      = VRAM_DATA_W,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       wr_stall_cnt
);

    gnt_t              gnt;
    rr_t               rr_q, rr_d;
    cpu_st_t           cpu_st_q, cpu_st_d;
    logic              cpu_pend;
    logic              cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic              disp_s1_q, disp_s1_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0]       stall_q, stall_d;
    wr_req_t           fifo_in, fifo_out;
    logic              fifo_full, fifo_empty;

    assign fifo_in.addr = wr_addr;
    assign fifo_in.data = wr_data;
    assign wr_ready     = !fifo_full;

    vram_wfifo #(
        .WIDTH ($bits(wr_req_t)),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_valid && wr_ready),
        .push_dat (fifo_in),
        .pop      (gnt == GNT_WR),
        .pop_dat  (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Grant: display first, then round-robin between queued draw writes and the pending CPU access.
    always_comb begin
        gnt = GNT_NONE;
        if (reset) begin
            gnt = GNT_NONE;
        end else if (disp_req) begin
            gnt = GNT_DISP;
        end else if (!fifo_empty && cpu_pend) begin
            gnt = (rr_q == RR_WR) ? GNT_WR : GNT_CPU;
        end else if (!fifo_empty) begin
            gnt = GNT_WR;
        end else if (cpu_pend) begin
            gnt = GNT_CPU;
        end
    end

    // BRAM port driven straight from the winner.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GNT_DISP: begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end
            GNT_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_out.addr;
                mem_wdata = fifo_out.data;
            end
            GNT_CPU: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we_q;
                mem_addr  = cpu_addr_q;
                mem_wdata = cpu_wdata_q;
            end
            default: ;
        endcase
    end

    // CPU FSM next state: latch on an idle request, wait for a slot, then one read-data cycle.
    always_comb begin
        cpu_st_d = cpu_st_q;
        case (cpu_st_q)
            CPU_IDLE: if (cpu_req) cpu_st_d = CPU_PEND;
            CPU_PEND: if (gnt == GNT_CPU) cpu_st_d = CPU_WAIT;
            CPU_WAIT: cpu_st_d = CPU_IDLE;
            default:  cpu_st_d = CPU_IDLE;
        endcase
    end

    // CPU FSM outputs: busy covers both pending and in-flight.
    always_comb begin
        cpu_pend = (cpu_st_q == CPU_PEND);
        cpu_busy = (cpu_st_q != CPU_IDLE);
    end

    // Next values for the request latch, read pipeline, pointer and stall counter.
    always_comb begin
        cpu_we_d    = cpu_we_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        if (cpu_st_q == CPU_IDLE && cpu_req) begin
            cpu_we_d    = cpu_we;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end
        disp_s1_d     = (gnt == GNT_DISP);
        disp_rvalid_d = disp_s1_q;
        disp_rdata_d  = disp_s1_q ? mem_rdata : disp_rdata_q;
        cpu_ack_d     = (cpu_st_q == CPU_WAIT);
        cpu_rdata_d   = (cpu_st_q == CPU_WAIT && !cpu_we_q) ? mem_rdata : cpu_rdata_q;
        // A lone shared-slot winner still hands the next tie to the other side.
        rr_d = rr_q;
        if (gnt == GNT_WR) rr_d = RR_CPU;
        if (gnt == GNT_CPU) rr_d = RR_WR;
        stall_d = stall_q;
        if (wr_valid && !wr_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    // State registers; reset drops any pending or in-flight access without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_st_q      <= CPU_IDLE;
            rr_q          <= RR_WR;
            cpu_we_q      <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_wdata_q   <= '0;
            disp_s1_q     <= 1'b0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            stall_q       <= '0;
        end else begin
            cpu_st_q      <= cpu_st_d;
            rr_q          <= rr_d;
            cpu_we_q      <= cpu_we_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_wdata_q   <= cpu_wdata_d;
            disp_s1_q     <= disp_s1_d;
            disp_rvalid_q <= disp_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            stall_q       <= stall_d;
        end
    end

    assign disp_rvalid  = disp_rvalid_q;
    assign disp_rdata   = disp_rdata_q;
    assign cpu_ack      = cpu_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign wr_stall_cnt = stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency BRAM model.
// Latency: checks are taken 2 time units after the active edge.
// Backpressure: exercised by holding display requests while draw writes queue up.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        disp_req;
    logic [16:0] disp_addr;
    logic [7:0]  disp_rdata;
    logic        disp_rvalid;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] wr_stall_cnt;

    logic        pre_we;
    logic [16:0] pre_addr;
    logic [7:0]  pre_dat;
    logic [7:0]  mem [0:131071];

    int n_total = 0;
    int n_pass  = 0;
    int acks;

    vram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_rdata   (disp_rdata),
        .disp_rvalid  (disp_rvalid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_busy     (cpu_busy),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .wr_stall_cnt (wr_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with registered read data, plus a preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_dat;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_dat = '0;
        idle_inputs();

        // Preload while in reset
        tick(); pre_we = 1'b1; pre_addr = 17'h00010; pre_dat = 8'hA5;
        tick(); pre_addr = 17'h00100; pre_dat = 8'h3C;
        tick(); pre_we = 1'b0;
        tick();

        // ---- Reset state
        tick(); reset = 1'b0; #1;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_disp_rvalid", disp_rvalid, 0);
        chk("rst_disp_rdata", disp_rdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_stall", wr_stall_cnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);

        // ---- Display read, 2-cycle latency
        tick(); disp_req = 1'b1; disp_addr = 17'h00010; #1;
        chk("d_mem_en", mem_en, 1);
        chk("d_mem_we", mem_we, 0);
        chk("d_mem_addr", mem_addr, 17'h00010);
        tick(); disp_req = 1'b0; #1;
        chk("d_rvalid_t1", disp_rvalid, 0);
        chk("d_mem_we_t1", mem_we, 0);
        tick(); #1;
        chk("d_rvalid_t2", disp_rvalid, 1);
        chk("d_rdata_t2", disp_rdata, 8'hA5);
        tick(); #1;
        chk("d_rvalid_t3", disp_rvalid, 0);

        // ---- FIFO + CPU read contention: WR, CPU, WR
        tick(); disp_req = 1'b1; disp_addr = 17'h00010;
        wr_valid = 1'b1; wr_addr = 17'h00300; wr_data = 8'h61;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00100; #1;
        chk("c_busy_d0", cpu_busy, 0);
        tick(); cpu_req = 1'b0; wr_addr = 17'h00301; wr_data = 8'h62; #1;
        chk("c_busy_d1", cpu_busy, 1);
        chk("c_gnt_d1_disp", mem_addr, 17'h00010);
        tick(); disp_req = 1'b0; wr_valid = 1'b0; #1;
        chk("c_g1_we", mem_we, 1);
        chk("c_g1_addr", mem_addr, 17'h00300);
        chk("c_g1_data", mem_wdata, 8'h61);
        tick(); #1;
        chk("c_g2_en", mem_en, 1);
        chk("c_g2_we", mem_we, 0);
        chk("c_g2_addr", mem_addr, 17'h00100);
        tick(); #1;
        chk("c_g3_we", mem_we, 1);
        chk("c_g3_addr", mem_addr, 17'h00301);
        chk("c_ack_early", cpu_ack, 0);
        chk("c_busy_g3", cpu_busy, 1);
        tick(); #1;
        chk("c_ack", cpu_ack, 1);
        chk("c_rdata", cpu_rdata, 8'h3C);
        chk("c_busy_drop", cpu_busy, 0);
        chk("c_idle_en", mem_en, 0);
        tick(); #1;
        chk("c_ack_pulse", cpu_ack, 0);

        // ---- FIFO fill under continuous display, stall counting
        tick(); disp_req = 1'b1; disp_addr = 17'h00010;
        wr_valid = 1'b1; wr_addr = 17'h00200; wr_data = 8'h50; #1;
        chk("f_ready_0", wr_ready, 1);
        for (int i = 1; i < 6; i++) begin
            tick(); wr_addr = 17'h00200 + 17'(i); wr_data = 8'h50 + 8'(i); #1;
            chk($sformatf("f_ready_%0d", i), wr_ready, (i < 4) ? 1 : 0);
            chk($sformatf("f_nowe_%0d", i), mem_we, 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); wr_valid = 1'b0; #1;
            chk("f_disp_hold_we", mem_we, 0);
        end
        tick(); disp_req = 1'b0; #1;
        chk("f_ready_full_pop", wr_ready, 0);
        chk("f_stall", wr_stall_cnt, 2);
        chk("f_r0_we", mem_we, 1);
        chk("f_r0_addr", mem_addr, 17'h00200);
        chk("f_r0_data", mem_wdata, 8'h50);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            chk($sformatf("f_r%0d_addr", i), mem_addr, 17'h00200 + 17'(i));
            chk($sformatf("f_r%0d_data", i), mem_wdata, 8'h50 + 8'(i));
            chk("f_ready_draining", wr_ready, 1);
        end
        tick(); wr_valid = 1'b1; wr_addr = 17'h00204; wr_data = 8'h54; #1;
        chk("f_no_bypass", mem_en, 0);
        tick(); wr_addr = 17'h00205; wr_data = 8'h55; #1;
        chk("f_r4_addr", mem_addr, 17'h00204);
        chk("f_r4_data", mem_wdata, 8'h54);
        tick(); wr_valid = 1'b0; #1;
        chk("f_r5_addr", mem_addr, 17'h00205);
        chk("f_r5_data", mem_wdata, 8'h55);
        tick(); #1;
        chk("f_drained", mem_en, 0);
        chk("f_stall_hold", wr_stall_cnt, 2);
        tick(); disp_req = 1'b1; disp_addr = 17'h00203;
        tick(); disp_req = 1'b0;
        tick(); #1;
        chk("f_readback", disp_rdata, 8'h53);

        // ---- Second CPU request while busy is ignored
        tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00120; cpu_wdata = 8'h11; #1;
        chk("i_busy_e0", cpu_busy, 0);
        acks = 0;
        tick(); cpu_wdata = 8'h22; #1;
        chk("i_busy_e1", cpu_busy, 1);
        chk("i_we", mem_we, 1);
        chk("i_wdata", mem_wdata, 8'h11);
        acks += int'(cpu_ack);
        tick(); cpu_req = 1'b0; #1;
        acks += int'(cpu_ack);
        tick(); #1;
        chk("i_ack", cpu_ack, 1);
        acks += int'(cpu_ack);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            acks += int'(cpu_ack);
        end
        chk("i_ack_count", acks, 1);
        tick(); disp_req = 1'b1; disp_addr = 17'h00120;
        tick(); disp_req = 1'b0;
        tick(); #1;
        chk("i_readback", disp_rdata, 8'h11);

        // ---- Reset one cycle after a CPU grant, FIFO holding entries
        tick(); disp_req = 1'b1; disp_addr = 17'h00010;
        wr_valid = 1'b1; wr_addr = 17'h00400; wr_data = 8'h70;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00130; cpu_wdata = 8'h99;
        tick(); cpu_req = 1'b0; wr_addr = 17'h00401; wr_data = 8'h71;
        tick(); wr_addr = 17'h00402; wr_data = 8'h72;
        tick(); disp_req = 1'b0; wr_valid = 1'b0; #1;
        chk("r_g_wr", mem_addr, 17'h00400);
        tick(); #1;
        chk("r_g_cpu", mem_addr, 17'h00130);
        chk("r_g_cpu_we", mem_we, 1);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("r_ack", cpu_ack, 0);
        chk("r_busy", cpu_busy, 0);
        chk("r_rvalid", disp_rvalid, 0);
        chk("r_ready", wr_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("r_no_mem_en", mem_en, 0);
            chk("r_no_ack", cpu_ack, 0);
        end

        // ---- Stall counter saturation
        tick(); disp_req = 1'b1; disp_addr = 17'h00010;
        wr_valid = 1'b1; wr_addr = 17'h00500; wr_data = 8'h01;
        repeat (1000) tick();
        chk("s_count_1000", wr_stall_cnt, 996);
        repeat (69000) tick();
        chk("s_saturated", wr_stall_cnt, 16'hFFFF);
        chk("s_ready_low", wr_ready, 0);
        tick();
        chk("s_no_wrap", wr_stall_cnt, 16'hFFFF);

        idle_inputs();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port frame-buffer BRAM, 320x240 at 8 bpp, between three requesters: the display pixel fetch, the sprite/draw engine's write stream and the MicroBlaze GPIO/AXI bridge.
- Sits in the pixel clock domain (clk_25MHz) between the color mapper path and the BRAM.
- Display reads get absolute priority with fixed latency. Draw writes are buffered in a small FIFO. The draw FIFO and CPU accesses share the remaining slots round-robin.

Parameters:
- ADDR_W, 17, frame-buffer word address width (76800 words).
- DATA_W, 8, pixel word width.
- WFIFO_DEPTH, 4, draw-write FIFO entries (power of two, >=2).

Ports:
- clk  in  1  pixel clock (25 MHz).
- reset  in  1  synchronous, active-high.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_rdata  out  DATA_W  display read data.
- disp_rvalid  out  1  disp_rdata valid.
- wr_valid  in  1  draw write offered.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ADDR_W  draw write address.
- wr_data  in  DATA_W  draw write data.
- cpu_req  in  1  one-cycle CPU access request pulse.
- cpu_we  in  1  1 = write, 0 = read (sampled with cpu_req).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_busy  out  1  CPU access pending.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, one-cycle latency.
- wr_stall_cnt  out  16  saturating count of cycles with wr_valid && !wr_ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values:
  - FIFO empty, so wr_ready=1 in the first cycle after reset.
  - cpu_busy=0, cpu_ack=0, disp_rvalid=0.
  - disp_rdata=0, cpu_rdata=0, wr_stall_cnt=0.
  - Round-robin pointer = WR.
  - mem_en=0, mem_we=0.
- Grant: exactly one grant per cycle, combinational from current requests and registered state.
  1. disp_req=1 -> GNT_DISP.
  2. Otherwise, among {FIFO non-empty, cpu pending}: if both, grant the one the round-robin pointer selects, then point at the other. If only one, grant it; the pointer still moves to the other.
  3. No requester -> GNT_NONE, mem_en=0.
- Memory drive in grant cycle t:
  - mem_en=1 for any grant.
  - mem_we=1 for GNT_WR and for CPU writes.
  - mem_addr and mem_wdata are muxed from the winner.
  - Outputs are combinational from the grant.
- Display latency:
  - disp_req at cycle t -> disp_rdata registered from mem_rdata at the end of t+1 -> disp_rvalid=1 in cycle t+2.
  - Fixed 2 cycles, never stalled.
  - Back-to-back disp_req gives back-to-back disp_rvalid.
- CPU:
  - cpu_req && !cpu_busy latches we, addr and wdata; cpu_busy=1 from the next cycle.
  - cpu_req while busy is ignored, with no queuing.
  - If the CPU is granted at cycle t, cpu_ack=1 for one cycle at t+2 (reads and writes alike), with cpu_rdata captured for reads. cpu_busy drops in the same cycle as cpu_ack.
  - During active video with continuous disp_req, the CPU waits until blanking.
- Write FIFO:
  - wr_ready = !full.
  - Push on wr_valid && wr_ready. Pop on GNT_WR. No bypass: an entry pushed at t is grantable at t+1 at the earliest.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
  - When full, wr_ready=0 even if a pop occurs that cycle (registered ready).
  - Writes retire to memory in push order.
- wr_stall_cnt increments each cycle wr_valid && !wr_ready, saturating at 16'hFFFF.
- Reset mid-operation: FIFO flushed, pending CPU access dropped with no cpu_ack, in-flight read pipeline cleared (no rvalid/ack after reset).
- Address range: addresses at or above 76800 are passed through unchecked; upstream owns range.

Decomposition:
- Package vram_pkg:
  - typedef enum logic [1:0] gnt_t {GNT_NONE, GNT_DISP, GNT_WR, GNT_CPU}.
  - localparams FB_W=320, FB_H=240, FB_WORDS=76800.
  - packed struct wr_req_t {addr, data}.
- Sub-module: vram_wfifo (synchronous FIFO with pointers, occupancy count and full/empty flags), instantiated once.
- Arbitration and the read pipeline stay in vram_arbiter.

Test Plan:
- Reset, then disp_req with addr=0x00010 and mem model [0x10]=0xA5 -> disp_rvalid=1 and disp_rdata=0xA5 exactly 2 cycles later; mem_we never asserted.
- Hold disp_req for 10 cycles while wr_valid pushes 6 writes -> wr_ready drops after 4 accepted, wr_stall_cnt=2 (wr_valid held 2 cycles while full). After disp_req falls, 4 writes retire in order, then the remaining 2.
- FIFO non-empty and CPU read of 0x00100 (=0x3C) pending, no disp_req -> grants alternate WR, CPU, WR. cpu_ack at grant+2 with cpu_rdata=0x3C; cpu_busy low from that cycle.
- Second cpu_req while cpu_busy=1 -> ignored: exactly one cpu_ack, and memory shows only the first write's data.
- Assert reset 1 cycle after a CPU grant with 3 FIFO entries -> no cpu_ack, disp_rvalid=0, wr_ready=1, no further mem_we.
- Force wr_valid high with FIFO full for 70000 cycles -> wr_stall_cnt saturates at 0xFFFF.
